// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared state encoding and framing constants for uart_cmd_ctrl
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        HUNT,
        ADDR,
        LEN,
        DATA,
        CHK,
        DRAIN
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         HDR_BYTES = 3;

endpackage

// File: rtl/uart_cmd_buf.sv
// rtl/uart_cmd_buf.sv - payload buffer: sequential write while framing, sequential read while draining
module uart_cmd_buf #(
    parameter int MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ptr_clr_i,
    input  logic       wr_en_i,
    input  logic [7:0] wr_data_i,
    input  logic       rd_adv_i,
    output logic [7:0] rd_data_o
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [7:0]    mem_q [MAX_LEN];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (ptr_clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_adv_i) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage carries no reset; contents are only read after a full frame has been written.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - frames UART bytes into checksummed register writes; UART_CMD_TIMEOUT_EN adds inter-byte timeout
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int CLK_FREQ      = 12_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int MAX_LEN       = 16,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_ok,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_overrun,
    output logic       err_timeout
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     state_q;
    logic [7:0] addr_q;
    logic [7:0] len_q;
    logic [7:0] sum_q;
    logic [7:0] idx_q;
    logic       wr_valid_q;
    logic [7:0] wr_addr_q;
    logic [7:0] wr_data_q;
    logic       frame_ok_q;
    logic       err_chk_q;
    logic       err_len_q;
    logic       err_overrun_q;

    logic       buf_clr;
    logic       buf_wr;
    logic       buf_adv;
    logic [7:0] buf_rd;
    logic       last_beat;
    logic       chk_match;

    assign last_beat = (idx_q == len_q - 8'd1);
    assign chk_match = (rx_data == sum_q);

    assign buf_clr = (state_q == LEN) && rx_valid;
    assign buf_wr  = (state_q == DATA) && rx_valid;
    // Read pointer runs one entry ahead of the presented write so the next byte is ready at handshake.
    assign buf_adv = ((state_q == CHK) && rx_valid && chk_match) ||
                     ((state_q == DRAIN) && wr_valid_q && wr_ready && !last_beat);

    uart_cmd_buf #(
        .MAX_LEN(MAX_LEN)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .ptr_clr_i(buf_clr),
        .wr_en_i  (buf_wr),
        .wr_data_i(rx_data),
        .rd_adv_i (buf_adv),
        .rd_data_o(buf_rd)
    );

`ifdef UART_CMD_TIMEOUT_EN
    localparam longint TO_RELOAD = (longint'(TIMEOUT_BYTES) * 64'd10 * longint'(CLK_FREQ)) / longint'(BAUD_RATE);
    localparam int     TO_W      = $clog2(TO_RELOAD + 1);

    logic [TO_W-1:0] to_q;
    logic            err_timeout_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            addr_q        <= 8'h00;
            len_q         <= 8'h00;
            sum_q         <= 8'h00;
            idx_q         <= 8'h00;
            wr_valid_q    <= 1'b0;
            wr_addr_q     <= 8'h00;
            wr_data_q     <= 8'h00;
            frame_ok_q    <= 1'b0;
            err_chk_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_overrun_q <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
            to_q          <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            frame_ok_q    <= 1'b0;
            err_chk_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_overrun_q <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (rx_valid && rx_data == SYNC_BYTE) state_q <= ADDR;
                end
                ADDR: begin
                    if (rx_valid) begin
                        addr_q  <= rx_data;
                        sum_q   <= rx_data;
                        state_q <= LEN;
                    end
                end
                LEN: begin
                    if (rx_valid) begin
                        if (rx_data == 8'h00 || rx_data > MAX_LEN_B) begin
                            err_len_q <= 1'b1;
                            state_q   <= HUNT;
                        end else begin
                            len_q   <= rx_data;
                            sum_q   <= sum_q + rx_data;
                            idx_q   <= 8'h00;
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        sum_q <= sum_q + rx_data;
                        idx_q <= idx_q + 8'd1;
                        if (last_beat) state_q <= CHK;
                    end
                end
                CHK: begin
                    if (rx_valid) begin
                        if (chk_match) begin
                            wr_valid_q <= 1'b1;
                            wr_addr_q  <= addr_q;
                            wr_data_q  <= buf_rd;
                            idx_q      <= 8'h00;
                            state_q    <= DRAIN;
                        end else begin
                            err_chk_q <= 1'b1;
                            state_q   <= HUNT;
                        end
                    end
                end
                DRAIN: begin
                    if (rx_valid) err_overrun_q <= 1'b1;
                    if (wr_valid_q && wr_ready) begin
                        if (last_beat) begin
                            wr_valid_q <= 1'b0;
                            frame_ok_q <= 1'b1;
                            state_q    <= HUNT;
                        end else begin
                            idx_q     <= idx_q + 8'd1;
                            wr_addr_q <= wr_addr_q + 8'd1;
                            wr_data_q <= buf_rd;
                        end
                    end
                end
                default: state_q <= HUNT;
            endcase
`ifdef UART_CMD_TIMEOUT_EN
            // An arriving byte always beats expiry in the same cycle.
            err_timeout_q <= 1'b0;
            if (rx_valid) begin
                to_q <= TO_W'(TO_RELOAD);
            end else if (state_q == ADDR || state_q == LEN || state_q == DATA || state_q == CHK) begin
                if (to_q == '0) begin
                    err_timeout_q <= 1'b1;
                    state_q       <= HUNT;
                end else begin
                    to_q <= to_q - 1'b1;
                end
            end
`endif
        end
    end

    assign wr_valid    = wr_valid_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_ok    = frame_ok_q;
    assign err_chk     = err_chk_q;
    assign err_len     = err_len_q;
    assign err_overrun = err_overrun_q;
`ifdef UART_CMD_TIMEOUT_EN
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - randomized self-checking bench for uart_cmd_ctrl (UART_CMD_TIMEOUT_EN aware)
module tb_uart_cmd_ctrl;

    localparam int MAX_LEN = 16;
    localparam int TO_CYC  = (4 * 10 * 12_000_000) / 115200;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_ok;
    logic       err_chk;
    logic       err_len;
    logic       err_overrun;
    logic       err_timeout;

    uart_cmd_ctrl #(
        .CLK_FREQ(12_000_000), .BAUD_RATE(115200), .MAX_LEN(MAX_LEN), .TIMEOUT_BYTES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_ok(frame_ok), .err_chk(err_chk), .err_len(err_len),
        .err_overrun(err_overrun), .err_timeout(err_timeout)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int ready_mode = 0;
    bit skip_stab  = 0;
    bit prev_stall = 0;
    logic [7:0] prev_addr, prev_data;

    logic [15:0] got_q[$];
    int          got_t[$];
    logic [15:0] exp_q[$];
    int ok_cnt, chk_cnt, len_cnt, ovr_cnt, to_cnt, ok_t, to_t;
    int e_ok, e_chk, e_len;
    logic [7:0] pay [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Observer: drives wr_ready, records handshakes and pulses, checks hold-while-stalled.
    always @(negedge clk) begin
        if (ready_mode == 0) wr_ready = 1'b1;
        else if (ready_mode == 1) wr_ready = 1'($urandom_range(0, 1));
        else wr_ready = 1'b0;
        if (prev_stall && rst_n && !skip_stab) begin
            total++;
            if (wr_valid !== 1'b1 || wr_addr !== prev_addr || wr_data !== prev_data) begin
                bad++;
                $display("FAIL hold_stable: got v=%b a=%h d=%h want v=1 a=%h d=%h",
                         wr_valid, wr_addr, wr_data, prev_addr, prev_data);
            end
        end
        prev_stall = rst_n && (wr_valid === 1'b1) && !wr_ready;
        prev_addr  = wr_addr;
        prev_data  = wr_data;
        if (rst_n && wr_valid === 1'b1 && wr_ready) begin
            got_q.push_back({wr_addr, wr_data});
            got_t.push_back(cyc);
        end
        if (frame_ok === 1'b1) begin ok_cnt++; ok_t = cyc; end
        if (err_chk === 1'b1) chk_cnt++;
        if (err_len === 1'b1) len_cnt++;
        if (err_overrun === 1'b1) ovr_cnt++;
        if (err_timeout === 1'b1) begin to_cnt++; to_t = cyc; end
    end

    task automatic clear_obs();
        ok_cnt = 0; chk_cnt = 0; len_cnt = 0; ovr_cnt = 0; to_cnt = 0;
        got_q.delete(); got_t.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Reference model: expected writes and outcome follow directly from the frame rules.
    task automatic send_frame(input logic [7:0] addr, input int len, input logic [7:0] chk_xor);
        logic [7:0] sum;
        exp_q.delete();
        e_ok = 0; e_chk = 0; e_len = 0;
        sum = addr + 8'(len);
        send_byte(8'hA5);
        send_byte(addr);
        send_byte(8'(len));
        if (len == 0 || len > MAX_LEN) begin
            e_len = 1;
            return;
        end
        for (int i = 0; i < len; i++) begin
            send_byte(pay[i]);
            sum = sum + pay[i];
            exp_q.push_back({8'(addr + 8'(i)), pay[i]});
        end
        send_byte(sum ^ chk_xor);
        if (chk_xor != 8'h00) begin
            exp_q.delete();
            e_chk = 1;
        end else begin
            e_ok = 1;
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (ok_cnt + chk_cnt + len_cnt + to_cnt == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL %s_timeout_wait: no completion pulse after %0d cycles", tag, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] addr, input int len, input logic [7:0] chk_xor);
        clear_obs();
        send_frame(addr, len, chk_xor);
        wait_done(tag);
        total++;
        if (ok_cnt !== e_ok || chk_cnt !== e_chk || len_cnt !== e_len) begin
            bad++;
            $display("FAIL %s_pulses: got ok=%0d chk=%0d len=%0d want ok=%0d chk=%0d len=%0d",
                     tag, ok_cnt, chk_cnt, len_cnt, e_ok, e_chk, e_len);
        end
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s_count: got %0d writes want %0d", tag, got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL %s_write%0d: got %h want %h", tag, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        total++;
        if ({wr_valid, wr_addr, wr_data} !== 17'h0) begin
            bad++;
            $display("FAIL reset_wr: got v=%b a=%h d=%h want 0 00 00", wr_valid, wr_addr, wr_data);
        end
        total++;
        if ({frame_ok, err_chk, err_len, err_overrun, err_timeout} !== 5'b0) begin
            bad++;
            $display("FAIL reset_pulses: got %b want 00000",
                     {frame_ok, err_chk, err_len, err_overrun, err_timeout});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        ready_mode = 0;
        pay[0] = 8'h11; pay[1] = 8'h22;
        run_frame("basic", 8'h10, 2, 8'h00);
        total++;
        if (got_t.size() != 2 || got_t[1] != got_t[0] + 1 || ok_t != got_t[1] + 1) begin
            bad++;
            $display("FAIL basic_timing: got %0d writes, ok_t=%0d want consecutive writes then frame_ok", got_t.size(), ok_t);
        end
    endtask

    task automatic test_bad_chk();
        ready_mode = 0;
        pay[0] = 8'h11; pay[1] = 8'h22;
        run_frame("badchk", 8'h10, 2, 8'h01);
        pay[0] = 8'h33; pay[1] = 8'h44;
        run_frame("afterchk", 8'h20, 2, 8'h00);
    endtask

    task automatic test_len();
        ready_mode = 0;
        run_frame("len0", 8'h30, 0, 8'h00);
        run_frame("lenover", 8'h30, MAX_LEN + 1, 8'h00);
        for (int i = 0; i < MAX_LEN; i++) pay[i] = 8'($urandom);
        run_frame("lenmax", 8'h40, MAX_LEN, 8'h00);
    endtask

    task automatic test_stalls();
        ready_mode = 1;
        pay[0] = 8'h5C; pay[1] = 8'hC5;
        run_frame("wrap", 8'hFF, 2, 8'h00);
        for (int f = 0; f < 6; f++) begin
            int len;
            len = $urandom_range(1, MAX_LEN);
            for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
            if (f == 0) pay[0] = 8'hA5;
            run_frame("rand", 8'($urandom), len, 8'h00);
        end
        ready_mode = 0;
    endtask

    task automatic test_overrun();
        clear_obs();
        ready_mode = 2;
        for (int i = 0; i < 3; i++) pay[i] = 8'($urandom);
        send_frame(8'h80, 3, 8'h00);
        send_byte(8'h5A);
        repeat (2) @(negedge clk);
        total++;
        if (ovr_cnt !== 1 || wr_valid !== 1'b1 || got_q.size() != 0) begin
            bad++;
            $display("FAIL overrun_pulse: got ovr=%0d v=%b writes=%0d want 1 1 0", ovr_cnt, wr_valid, got_q.size());
        end
        ready_mode = 1;
        wait_done("overrun");
        total++;
        if (ok_cnt !== 1 || got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL overrun_drain: got ok=%0d writes=%0d want 1 %0d", ok_cnt, got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL overrun_write%0d: got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        ready_mode = 0;
    endtask

    task automatic test_reset_mid_drain();
        clear_obs();
        ready_mode = 2;
        for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
        send_frame(8'h90, 4, 8'h00);
        skip_stab = 1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (wr_valid !== 1'b0 || wr_addr !== 8'h00) begin
            bad++;
            $display("FAIL rst_drain: got v=%b a=%h want 0 00", wr_valid, wr_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 0;
        repeat (2) @(negedge clk);
        skip_stab = 0;
        total++;
        if (got_q.size() != 0 || ok_cnt != 0) begin
            bad++;
            $display("FAIL rst_lost: got writes=%0d ok=%0d want 0 0", got_q.size(), ok_cnt);
        end
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
        run_frame("afterrst", 8'hA0, 3, 8'h00);
    endtask

    task automatic test_timeout();
        int t0;
        clear_obs();
        ready_mode = 0;
        send_byte(8'hA5);
        send_byte(8'h10);
        t0 = cyc;
`ifdef UART_CMD_TIMEOUT_EN
        while (to_cnt == 0 && cyc - t0 < TO_CYC + 50) @(negedge clk);
        total++;
        if (to_cnt != 1 || to_t - t0 < TO_CYC || to_t - t0 > TO_CYC + 2) begin
            bad++;
            $display("FAIL timeout_pulse: got cnt=%0d delay=%0d want 1 %0d", to_cnt, to_t - t0, TO_CYC + 1);
        end
        pay[0] = 8'h11; pay[1] = 8'h22;
        run_frame("aftertimeout", 8'h10, 2, 8'h00);
`else
        repeat (TO_CYC + 200) @(negedge clk);
        total++;
        if (to_cnt != 0) begin
            bad++;
            $display("FAIL timeout_off: got %0d pulses want 0", to_cnt);
        end
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h45);
        wait_done("resume");
        total++;
        if (ok_cnt != 1 || got_q.size() != 2) begin
            bad++;
            $display("FAIL resume_count: got ok=%0d writes=%0d want 1 2", ok_cnt, got_q.size());
        end else begin
            total++;
            if (got_q[0] !== 16'h1011 || got_q[1] !== 16'h1122) begin
                bad++;
                $display("FAIL resume_writes: got %h %h want 1011 1122", got_q[0], got_q[1]);
            end
        end
`endif
    endtask

    initial begin
        wr_ready = 1'b1;
        test_reset();
        test_basic();
        test_bad_chk();
        test_len();
        test_stalls();
        test_overrun();
        test_reset_mid_drain();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
